// File: rtl/dram_port_arbiter.sv
// Round-robin arbiter between the CPU data port (master 0) and the debug/loader
// port (master 1) in front of a single-port, 1-cycle-latency data RAM.
module dram_port_arbiter #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              m0_req,
    input  logic [3:0]        m0_we,
    input  logic [31:0]       m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ready,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,

    input  logic              m1_req,
    input  logic [3:0]        m1_we,
    input  logic [31:0]       m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ready,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,

    output logic [ADDR_W-1:0] ram_addr,
    output logic [3:0]        ram_we,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    logic       last_gnt;
    logic       rd_pend;
    logic       rd_owner;
    logic       gnt;
    logic       any_req;
    logic [3:0] sel_we;

    // Byte-lane and high address bits are don't-care for a word-addressed RAM.
    logic unused_addr;
    assign unused_addr = ^{m0_addr[31:ADDR_W+2], m0_addr[1:0],
                           m1_addr[31:ADDR_W+2], m1_addr[1:0]};

    always_comb begin
        any_req = m0_req | m1_req;
        gnt     = 1'b0;
        if (m0_req && m1_req) begin
            gnt = ~last_gnt;
        end else if (m1_req) begin
            gnt = 1'b1;
        end
    end

    // With no request gnt stays 0, so the RAM sees master 0's address/data.
    always_comb begin
        ram_addr = gnt ? m1_addr[ADDR_W+1:2] : m0_addr[ADDR_W+1:2];
        ram_din  = gnt ? m1_wdata : m0_wdata;
        sel_we   = gnt ? m1_we : m0_we;
        ram_we   = (any_req && !reset) ? sel_we : 4'h0;
        m0_ready = m0_req && !gnt && !reset;
        m1_ready = m1_req &&  gnt && !reset;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_gnt <= 1'b1;
            rd_pend  <= 1'b0;
            rd_owner <= 1'b0;
        end else if (any_req) begin
            last_gnt <= gnt;
            rd_pend  <= (sel_we == 4'h0);
            rd_owner <= gnt;
        end else begin
            rd_pend  <= 1'b0;
        end
    end

    assign m0_rvalid = rd_pend && !rd_owner;
    assign m1_rvalid = rd_pend &&  rd_owner;
    assign m0_rdata  = ram_dout;
    assign m1_rdata  = ram_dout;

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Directed vector bench for dram_port_arbiter with a write-first RAM model.
module tb_dram_port_arbiter;

    localparam int ADDR_W = 14;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        m0_req = 1'b0, m1_req = 1'b0;
    logic [3:0]  m0_we = 4'h0, m1_we = 4'h0;
    logic [31:0] m0_addr = 32'h0, m1_addr = 32'h0;
    logic [31:0] m0_wdata = 32'h0, m1_wdata = 32'h0;
    logic        m0_ready, m1_ready, m0_rvalid, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic [ADDR_W-1:0] ram_addr;
    logic [3:0]  ram_we;
    logic [31:0] ram_din;
    logic [31:0] ram_dout = 32'h0;

    int checks = 0;
    int errors = 0;

    dram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
        .clock(clock), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ready(m0_ready), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ready(m1_ready), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    always #5 clock = ~clock;

    // Write-first single-port RAM, 1-cycle read latency.
    logic [31:0] mem [0:(1<<ADDR_W)-1];
    always @(posedge clock) begin
        logic [31:0] w;
        w = mem[ram_addr];
        for (int b = 0; b < 4; b++)
            if (ram_we[b]) w[8*b +: 8] = ram_din[8*b +: 8];
        mem[ram_addr] <= w;
        ram_dout      <= w;
    end

    typedef struct {
        logic        rst;
        logic        r0;  logic [3:0] we0; logic [31:0] a0; logic [31:0] d0;
        logic        r1;  logic [3:0] we1; logic [31:0] a1; logic [31:0] d1;
        logic        e_rdy0, e_rdy1;
        logic [3:0]  e_we;
        logic [13:0] e_addr;
        logic        e_v0, e_v1;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t vecs [0:25];

    function automatic vec_t mk(logic rst,
            logic r0, logic [3:0] we0, logic [31:0] a0, logic [31:0] d0,
            logic r1, logic [3:0] we1, logic [31:0] a1, logic [31:0] d1,
            logic e_rdy0, logic e_rdy1, logic [3:0] e_we, logic [13:0] e_addr,
            logic e_v0, logic e_v1, logic [31:0] e_rdata);
        vec_t v;
        v.rst = rst;
        v.r0 = r0; v.we0 = we0; v.a0 = a0; v.d0 = d0;
        v.r1 = r1; v.we1 = we1; v.a1 = a1; v.d1 = d1;
        v.e_rdy0 = e_rdy0; v.e_rdy1 = e_rdy1; v.e_we = e_we; v.e_addr = e_addr;
        v.e_v0 = e_v0; v.e_v1 = e_v1; v.e_rdata = e_rdata;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(logic rst,
            logic r0, logic [3:0] we0, logic [31:0] a0, logic [31:0] d0,
            logic r1, logic [3:0] we1, logic [31:0] a1, logic [31:0] d1);
        reset = rst;
        m0_req = r0; m0_we = we0; m0_addr = a0; m0_wdata = d0;
        m1_req = r1; m1_we = we1; m1_addr = a1; m1_wdata = d1;
    endtask

    initial begin
        // rst  r0 we0   a0           d0            r1 we1   a1          d1            rdy0 rdy1 we    addr      v0 v1 rdata
        vecs[0]  = mk(0, 0,4'h0,32'h0,       32'h0,        0,4'h0,32'h0,  32'h0,        0,0,4'h0,14'h0,  0,0,32'h0);
        vecs[1]  = mk(0, 0,4'h0,32'h0,       32'h0,        1,4'hF,32'h10, 32'hDEADBEEF, 0,1,4'hF,14'h4,  0,0,32'h0);
        vecs[2]  = mk(0, 0,4'h0,32'h0,       32'h0,        1,4'h0,32'h10, 32'h0,        0,1,4'h0,14'h4,  0,0,32'h0);
        vecs[3]  = mk(0, 0,4'h0,32'h0,       32'h0,        0,4'h0,32'h0,  32'h0,        0,0,4'h0,14'h0,  0,1,32'hDEADBEEF);
        vecs[4]  = mk(1, 1,4'hF,32'h20,      32'h11223344, 1,4'hF,32'h30, 32'h55667788, 0,0,4'h0,14'h8,  0,0,32'h0);
        vecs[5]  = mk(1, 1,4'hF,32'h20,      32'h11223344, 1,4'hF,32'h30, 32'h55667788, 0,0,4'h0,14'h8,  0,0,32'h0);
        vecs[6]  = mk(0, 1,4'hF,32'h20,      32'h11223344, 1,4'hF,32'h30, 32'h55667788, 1,0,4'hF,14'h8,  0,0,32'h0);
        vecs[7]  = mk(0, 1,4'h2,32'h20,      32'h0000AA00, 1,4'hF,32'h30, 32'h55667788, 0,1,4'hF,14'hC,  0,0,32'h0);
        vecs[8]  = mk(0, 1,4'h2,32'h20,      32'h0000AA00, 1,4'h0,32'h30, 32'h0,        1,0,4'h2,14'h8,  0,0,32'h0);
        vecs[9]  = mk(0, 1,4'h0,32'h20,      32'h0,        1,4'h0,32'h30, 32'h0,        0,1,4'h0,14'hC,  0,0,32'h0);
        vecs[10] = mk(0, 1,4'h0,32'h20,      32'h0,        0,4'h0,32'h0,  32'h0,        1,0,4'h0,14'h8,  0,1,32'h55667788);
        vecs[11] = mk(0, 0,4'h0,32'h0,       32'h0,        0,4'h0,32'h0,  32'h0,        0,0,4'h0,14'h0,  1,0,32'h1122AA44);
        vecs[12] = mk(0, 1,4'hF,32'h0,       32'hA0A0A0A0, 0,4'h0,32'h0,  32'h0,        1,0,4'hF,14'h0,  0,0,32'h0);
        vecs[13] = mk(0, 0,4'h0,32'h0,       32'h0,        1,4'hF,32'h4,  32'hB1B1B1B1, 0,1,4'hF,14'h1,  0,0,32'h0);
        vecs[14] = mk(0, 1,4'h0,32'h0,       32'h0,        0,4'h0,32'h0,  32'h0,        1,0,4'h0,14'h0,  0,0,32'h0);
        vecs[15] = mk(0, 0,4'h0,32'h0,       32'h0,        1,4'h0,32'h4,  32'h0,        0,1,4'h0,14'h1,  1,0,32'hA0A0A0A0);
        vecs[16] = mk(0, 0,4'h0,32'h0,       32'h0,        0,4'h0,32'h0,  32'h0,        0,0,4'h0,14'h0,  0,1,32'hB1B1B1B1);
        vecs[17] = mk(0, 1,4'h0,32'h00010007,32'h0,        0,4'h0,32'h0,  32'h0,        1,0,4'h0,14'h1,  0,0,32'h0);
        vecs[18] = mk(0, 0,4'h0,32'h0,       32'h0,        0,4'h0,32'h0,  32'h0,        0,0,4'h0,14'h0,  1,0,32'hB1B1B1B1);
        vecs[19] = mk(0, 0,4'h0,32'h0,       32'h0,        1,4'hF,32'h40, 32'hCAFEF00D, 0,1,4'hF,14'h10, 0,0,32'h0);
        vecs[20] = mk(0, 0,4'h0,32'h0,       32'h0,        1,4'h0,32'h40, 32'h0,        0,1,4'h0,14'h10, 0,0,32'h0);
        vecs[21] = mk(0, 0,4'h0,32'h0,       32'h0,        0,4'h0,32'h0,  32'h0,        0,0,4'h0,14'h0,  0,1,32'hCAFEF00D);
        vecs[22] = mk(0, 1,4'h0,32'h0,       32'h0,        1,4'h0,32'h4,  32'h0,        1,0,4'h0,14'h0,  0,0,32'h0);
        vecs[23] = mk(0, 1,4'h0,32'h20,      32'h0,        1,4'h0,32'h4,  32'h0,        0,1,4'h0,14'h1,  1,0,32'hA0A0A0A0);
        vecs[24] = mk(0, 1,4'h0,32'h20,      32'h0,        0,4'h0,32'h0,  32'h0,        1,0,4'h0,14'h8,  0,1,32'hB1B1B1B1);
        vecs[25] = mk(0, 0,4'h0,32'h0,       32'h0,        0,4'h0,32'h0,  32'h0,        0,0,4'h0,14'h0,  1,0,32'h1122AA44);

        // Reset held for three cycles, then released with no requests.
        repeat (3) @(negedge clock);
        #1;
        check("rst_m0_ready", {31'h0, m0_ready}, 32'h0);
        check("rst_m1_rvalid", {31'h0, m1_rvalid}, 32'h0);
        check("rst_ram_we", {28'h0, ram_we}, 32'h0);

        for (int i = 0; i < 26; i++) begin
            @(negedge clock);
            drive(vecs[i].rst, vecs[i].r0, vecs[i].we0, vecs[i].a0, vecs[i].d0,
                  vecs[i].r1, vecs[i].we1, vecs[i].a1, vecs[i].d1);
            #1;
            check($sformatf("v%0d m0_ready", i), {31'h0, m0_ready}, {31'h0, vecs[i].e_rdy0});
            check($sformatf("v%0d m1_ready", i), {31'h0, m1_ready}, {31'h0, vecs[i].e_rdy1});
            check($sformatf("v%0d ram_we", i), {28'h0, ram_we}, {28'h0, vecs[i].e_we});
            check($sformatf("v%0d ram_addr", i), {18'h0, ram_addr}, {18'h0, vecs[i].e_addr});
            check($sformatf("v%0d m0_rvalid", i), {31'h0, m0_rvalid}, {31'h0, vecs[i].e_v0});
            check($sformatf("v%0d m1_rvalid", i), {31'h0, m1_rvalid}, {31'h0, vecs[i].e_v1});
            if (vecs[i].e_v0) check($sformatf("v%0d m0_rdata", i), m0_rdata, vecs[i].e_rdata);
            if (vecs[i].e_v1) check($sformatf("v%0d m1_rdata", i), m1_rdata, vecs[i].e_rdata);
        end

        // Reset arriving while a read is outstanding drops the rvalid.
        @(negedge clock);
        drive(0, 1, 4'h0, 32'h20, 32'h0, 0, 4'h0, 32'h0, 32'h0);
        @(negedge clock);
        #1;
        check("midrd_rvalid_before", {31'h0, m0_rvalid}, 32'h1);
        drive(1, 0, 4'h0, 32'h0, 32'h0, 0, 4'h0, 32'h0, 32'h0);
        #1;
        check("midrd_rvalid_dropped", {31'h0, m0_rvalid}, 32'h0);
        @(negedge clock);
        drive(0, 0, 4'h0, 32'h0, 32'h0, 0, 4'h0, 32'h0, 32'h0);
        #1;
        check("midrd_no_replay", {31'h0, m0_rvalid}, 32'h0);
        @(negedge clock);
        #1;
        check("midrd_no_replay2", {31'h0, m0_rvalid}, 32'h0);
        drive(0, 1, 4'h0, 32'h20, 32'h0, 1, 4'h0, 32'h4, 32'h0);
        #1;
        check("post_rst_conflict_m0", {31'h0, m0_ready}, 32'h1);
        check("post_rst_conflict_m1", {31'h0, m1_ready}, 32'h0);
        @(negedge clock);
        drive(0, 0, 4'h0, 32'h0, 32'h0, 1, 4'h0, 32'h4, 32'h0);
        #1;
        check("post_rst_m0_rvalid", {31'h0, m0_rvalid}, 32'h1);
        check("post_rst_m0_rdata", m0_rdata, 32'h1122AA44);
        check("post_rst_m1_ready", {31'h0, m1_ready}, 32'h1);
        @(negedge clock);
        drive(0, 0, 4'h0, 32'h0, 32'h0, 0, 4'h0, 32'h0, 32'h0);
        #1;
        check("post_rst_m1_rvalid", {31'h0, m1_rvalid}, 32'h1);
        check("post_rst_m1_rdata", m1_rdata, 32'hB1B1B1B1);
        check("post_rst_m0_quiet", {31'h0, m0_rvalid}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
